angle_entry_ctrl: RTL and testbench

Parametrised angle-entry controller for the CORDIC demo. It converts two raw push-buttons (increment, decrement) into a wrapped angle value and supports two selectable range limits. It adds input synchronisation, debounce, single-step on press and auto-repeat on hold, and reduces the angle to the first quadrant with registered sign and swap flags. It drives the input display and the CORDIC arithmetic block, and supplies the sign/swap flags used by the output display.

---
 rtl/angle_entry_ctrl_if.sv | 28 ++
 rtl/angle_entry_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_angle_entry_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/angle_entry_ctrl_if.sv
// Pin bundle for the angle-entry controller: raw buttons and mode select in,
// displayed angle plus first-quadrant reduced angle and sign/swap flags out.
interface angle_entry_ctrl_if #(
  parameter int ANGLE_W = 9,
  parameter int ARITH_W = 7
);
  logic               button_inc;
  logic               button_dec;
  logic               Mode_sel;
  logic [ANGLE_W-1:0] angle_to_show_in;
  logic [ARITH_W-1:0] angle_to_arith;
  logic               cos_sign_to_output;
  logic               sin_sign_to_output;
  logic               c_s_swap_to_output;
  logic               angle_valid;

  modport master (
    output button_inc, button_dec, Mode_sel,
    input  angle_to_show_in, angle_to_arith, cos_sign_to_output,
           sin_sign_to_output, c_s_swap_to_output, angle_valid
  );

  modport slave (
    input  button_inc, button_dec, Mode_sel,
    output angle_to_show_in, angle_to_arith, cos_sign_to_output,
           sin_sign_to_output, c_s_swap_to_output, angle_valid
  );
endinterface

// File: rtl/angle_entry_ctrl.sv
// Angle-entry controller: debounced inc/dec buttons with tap/auto-repeat, two
// wrap limits, and registered first-quadrant reduction for the CORDIC core.

// One button lane: 2-flop synchroniser followed by a stability counter.
module angle_entry_btn #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_db
);
  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchroniser clears to the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      btn_db <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      if (sync_q[1] != btn_db) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
          btn_db <= sync_q[1];
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end
endmodule

module angle_entry_ctrl #(
  parameter int FULL_ANGLE   = 360,
  parameter int ALT_MAX      = 79,
  parameter int ANGLE_W      = 9,
  parameter int ARITH_W      = 7,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int HOLD_CYC     = 25000000,
  parameter int REPEAT_CYC   = 5000000
) (
  input logic               clk,
  input logic               rst_n,
  angle_entry_ctrl_if.slave bus
);
  localparam int NUM_BTN = 2;
  localparam int STAGES  = 1;
  localparam int TMR_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;

  localparam logic [ANGLE_W-1:0] FULL_A = ANGLE_W'(FULL_ANGLE);
  localparam logic [ANGLE_W-1:0] ALT_A  = ANGLE_W'(ALT_MAX);
  localparam logic [ANGLE_W-1:0] Q1_A   = ANGLE_W'(FULL_ANGLE / 4);
  localparam logic [ANGLE_W-1:0] Q2_A   = ANGLE_W'(FULL_ANGLE / 2);
  localparam logic [ANGLE_W-1:0] Q3_A   = ANGLE_W'((FULL_ANGLE / 4) * 3);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  // Lane 0 = inc, lane 1 = dec; both active-low.
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_db;

  assign btn_raw = {bus.button_dec, bus.button_inc};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    angle_entry_btn #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_raw[g]),
      .btn_db  (btn_db[g])
    );
  end

  logic cmd_inc, cmd_dec, cmd_both;
  assign cmd_inc  = ~btn_db[0] &  btn_db[1];
  assign cmd_dec  =  btn_db[0] & ~btn_db[1];
  assign cmd_both = ~btn_db[0] & ~btn_db[1];

  logic [1:0] mode_sync_q;
  logic       mode_q;
  logic       mode_s, mode_chg;
  assign mode_s   = mode_sync_q[1];
  assign mode_chg = mode_s ^ mode_q;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               dir_q, dir_d;
  logic               step, step_up, cmd_held;

  logic [ANGLE_W-1:0] angle_q, angle_step, limit;
  logic [ARITH_W-1:0] arith_q;
  logic               cos_q, sin_q, swap_q;
  logic [STAGES:0]    vld_pipe;

  logic [ANGLE_W-1:0] red_a;
  logic               red_cos, red_sin, red_swap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_sync_q <= 2'b00;
      mode_q      <= 1'b0;
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      dir_q       <= 1'b0;
    end else begin
      mode_sync_q <= {mode_sync_q[0], bus.Mode_sel};
      mode_q      <= mode_s;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      dir_q       <= dir_d;
    end
  end

  // The latched direction must still be commanded for HOLD/REPEAT to continue.
  assign cmd_held = dir_q ? cmd_inc : cmd_dec;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    dir_d   = dir_q;
    step    = 1'b0;
    step_up = cmd_inc;
    if (mode_chg || cmd_both) begin
      state_d = S_IDLE;
      tmr_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_inc || cmd_dec) begin
            step    = 1'b1;
            dir_d   = cmd_inc;
            state_d = S_HOLD;
            tmr_d   = '0;
          end
        end
        S_HOLD: begin
          if (!cmd_held) begin
            state_d = S_IDLE;
            tmr_d   = '0;
          end else if (tmr_q == TMR_W'(HOLD_CYC - 1)) begin
            step    = 1'b1;
            state_d = S_REPEAT;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        S_REPEAT: begin
          if (!cmd_held) begin
            state_d = S_IDLE;
            tmr_d   = '0;
          end else if (tmr_q == TMR_W'(REPEAT_CYC - 1)) begin
            step  = 1'b1;
            tmr_d = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end
      endcase
    end
  end

  // On a mode-change cycle mode_s already carries the new mode, so the new limit applies.
  assign limit = mode_s ? ALT_A : FULL_A;

  always_comb begin
    if (step_up) angle_step = (angle_q >= limit) ? '0 : angle_q + 1'b1;
    else         angle_step = (angle_q == '0) ? limit : angle_q - 1'b1;
  end

  always_comb begin
    red_a    = angle_q;
    red_cos  = 1'b0;
    red_sin  = 1'b0;
    red_swap = 1'b0;
    if (angle_q <= Q1_A) begin
      red_a = angle_q;
    end else if (angle_q <= Q2_A) begin
      red_a    = angle_q - Q1_A;
      red_cos  = 1'b1;
      red_swap = 1'b1;
    end else if (angle_q <= Q3_A) begin
      red_a   = angle_q - Q2_A;
      red_cos = 1'b1;
      red_sin = 1'b1;
    end else begin
      red_a    = angle_q - Q3_A;
      red_sin  = 1'b1;
      red_swap = 1'b1;
    end
  end

  // vld_pipe[0] marks a change of angle_q; the reduced outputs trail it by one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle_q  <= '0;
      arith_q  <= '0;
      cos_q    <= 1'b0;
      sin_q    <= 1'b0;
      swap_q   <= 1'b0;
      vld_pipe <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      vld_pipe[0]        <= 1'b0;
      if (mode_chg) begin
        if (angle_q > limit) begin
          angle_q     <= '0;
          vld_pipe[0] <= 1'b1;
        end
      end else if (step) begin
        angle_q     <= angle_step;
        vld_pipe[0] <= 1'b1;
      end
      arith_q <= ARITH_W'(red_a);
      cos_q   <= red_cos;
      sin_q   <= red_sin;
      swap_q  <= red_swap;
    end
  end

  assign bus.angle_to_show_in   = angle_q;
  assign bus.angle_to_arith     = arith_q;
  assign bus.cos_sign_to_output = cos_q;
  assign bus.sin_sign_to_output = sin_q;
  assign bus.c_s_swap_to_output = swap_q;
  assign bus.angle_valid        = vld_pipe[STAGES];
endmodule

// File: tb/tb_angle_entry_ctrl.sv
// Directed bench for angle_entry_ctrl with short debounce/hold/repeat counts.
module tb_angle_entry_ctrl;
  localparam int DB  = 4;
  localparam int HLD = 20;
  localparam int RPT = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  angle_entry_ctrl_if #(.ANGLE_W(9), .ARITH_W(7)) bus();

  angle_entry_ctrl #(
    .FULL_ANGLE(360), .ALT_MAX(79), .ANGLE_W(9), .ARITH_W(7),
    .DEBOUNCE_CYC(DB), .HOLD_CYC(HLD), .REPEAT_CYC(RPT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total   = 0;
  int bad     = 0;
  int vld_cnt = 0;
  int v0;

  always @(negedge clk) if (bus.angle_valid === 1'b1) vld_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit up, input logic lvl);
    if (up) bus.button_inc = lvl;
    else    bus.button_dec = lvl;
  endtask

  // Press long enough for exactly one step, release well before the hold expires.
  task automatic tap(input bit up);
    @(negedge clk);
    drive(up, 1'b0);
    cyc(10);
    drive(up, 1'b1);
    cyc(12);
  endtask

  // Steps land at edges 7, 27, 32, ...; release so debounced release beats the next one.
  task automatic hold_n(input bit up, input int n);
    int last;
    last = 27 + RPT * (n - 2);
    @(negedge clk);
    drive(up, 1'b0);
    cyc(last - 5);
    drive(up, 1'b1);
    cyc(12);
  endtask

  task automatic chk_red(input string tag, input int ang, input int ar,
                         input int c, input int s, input int w);
    chk({tag, "_ang"},  int'(bus.angle_to_show_in), ang);
    chk({tag, "_ar"},   int'(bus.angle_to_arith), ar);
    chk({tag, "_cos"},  int'(bus.cos_sign_to_output), c);
    chk({tag, "_sin"},  int'(bus.sin_sign_to_output), s);
    chk({tag, "_swap"}, int'(bus.c_s_swap_to_output), w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    bus.button_inc = 1'b1;
    bus.button_dec = 1'b1;
    bus.Mode_sel   = 1'b0;
    cyc(3);
    chk_red("rst", 0, 0, 0, 0, 0);
    chk("rst_vld", int'(bus.angle_valid), 0);
    rst_n = 1'b1;
    cyc(3);

    // single tap with latency: step on edge 2+DB+1, reduced/valid one later
    v0 = vld_cnt;
    bus.button_inc = 1'b0;
    cyc(6);  chk("tap_pre", int'(bus.angle_to_show_in), 0);
    cyc(1);  chk("tap_step", int'(bus.angle_to_show_in), 1);
             chk("tap_ar_lag", int'(bus.angle_to_arith), 0);
             chk("tap_vld_lag", int'(bus.angle_valid), 0);
    cyc(1);  chk_red("tap", 1, 1, 0, 0, 0);
             chk("tap_vld", int'(bus.angle_valid), 1);
    cyc(1);  chk("tap_vld_off", int'(bus.angle_valid), 0);
    cyc(1);
    bus.button_inc = 1'b1;
    cyc(12);
    chk("tap_final", int'(bus.angle_to_show_in), 1);
    chk("tap_pulses", vld_cnt - v0, 1);

    // bounce: 3-cycle press glitches never reach DB stable cycles
    v0 = vld_cnt;
    for (int r = 0; r < 2; r++) begin
      bus.button_inc = 1'b0; cyc(3);
      bus.button_inc = 1'b1; cyc(1);
    end
    chk("bnc_quiet", int'(bus.angle_to_show_in), 1);
    bus.button_inc = 1'b0;
    cyc(6);  chk("bnc_pre", int'(bus.angle_to_show_in), 1);
    cyc(1);  chk("bnc_step", int'(bus.angle_to_show_in), 2);
    cyc(3);
    bus.button_inc = 1'b1;
    cyc(12);
    chk("bnc_pulses", vld_cnt - v0, 1);

    // auto-repeat: steps at edges 7, 27, 32, 37, 42; release after edge 40
    v0 = vld_cnt;
    bus.button_inc = 1'b0;
    cyc(7);  chk("rep_1st", int'(bus.angle_to_show_in), 3);
    cyc(19); chk("rep_hold", int'(bus.angle_to_show_in), 3);
    cyc(1);  chk("rep_2nd", int'(bus.angle_to_show_in), 4);
    cyc(4);  chk("rep_gap", int'(bus.angle_to_show_in), 4);
    cyc(1);  chk("rep_3rd", int'(bus.angle_to_show_in), 5);
    cyc(5);  chk("rep_4th", int'(bus.angle_to_show_in), 6);
    cyc(3);
    bus.button_inc = 1'b1;
    cyc(2);  chk("rep_5th", int'(bus.angle_to_show_in), 7);
    cyc(15); chk("rep_stop", int'(bus.angle_to_show_in), 7);
    chk("rep_pulses", vld_cnt - v0, 5);

    // wrap and quadrant reduction
    hold_n(1'b0, 7);
    chk("dn_to_0", int'(bus.angle_to_show_in), 0);
    tap(1'b0);
    chk_red("wrap_dn", 360, 90, 0, 1, 1);
    tap(1'b1);
    chk_red("wrap_up", 0, 0, 0, 0, 0);
    hold_n(1'b1, 91);
    chk_red("q2", 91, 1, 1, 0, 1);
    hold_n(1'b1, 90);
    chk_red("q3", 181, 1, 1, 1, 0);
    hold_n(1'b1, 19);
    chk("at_200", int'(bus.angle_to_show_in), 200);

    // alternate mode forces 200 -> 0 with one pulse
    v0 = vld_cnt;
    bus.Mode_sel = 1'b1;
    cyc(2);  chk("mode_pre", int'(bus.angle_to_show_in), 200);
    cyc(1);  chk("mode_force", int'(bus.angle_to_show_in), 0);
    cyc(1);  chk("mode_vld", int'(bus.angle_valid), 1);
    cyc(5);  chk("mode_pulses", vld_cnt - v0, 1);
    tap(1'b0);
    chk("alt_wrap_dn", int'(bus.angle_to_show_in), 79);
    tap(1'b1);
    chk("alt_wrap_up", int'(bus.angle_to_show_in), 0);
    v0 = vld_cnt;
    bus.Mode_sel = 1'b0;
    cyc(8);
    chk("mode_0to0_pulse", vld_cnt - v0, 0);

    // both pressed together: no step
    v0 = vld_cnt;
    bus.button_inc = 1'b0;
    bus.button_dec = 1'b0;
    cyc(40);
    chk("both_ang", int'(bus.angle_to_show_in), 0);
    chk("both_pulses", vld_cnt - v0, 0);
    bus.button_inc = 1'b1;
    bus.button_dec = 1'b1;
    cyc(12);

    // inc in HOLD, then dec joins: back to IDLE, hold expiry step suppressed
    bus.button_inc = 1'b0;
    cyc(10);
    bus.button_dec = 1'b0;
    cyc(30);
    chk("both_hold", int'(bus.angle_to_show_in), 1);
    bus.button_inc = 1'b1;
    bus.button_dec = 1'b1;
    cyc(12);
    chk("both_rel", int'(bus.angle_to_show_in), 1);

    // async reset during HOLD
    bus.button_inc = 1'b0;
    cyc(7);  chk("rh_step", int'(bus.angle_to_show_in), 2);
    cyc(5);
    rst_n = 1'b0;
    #1;
    chk_red("rh_rst", 0, 0, 0, 0, 0);
    chk("rh_vld", int'(bus.angle_valid), 0);
    bus.button_inc = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(30);
    chk("rh_idle", int'(bus.angle_to_show_in), 0);
    tap(1'b1);
    chk("rh_new_press", int'(bus.angle_to_show_in), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
